// File: rtl/dm_mmio_responder.sv
// Data-side memory responder: word RAM plus a small MMIO window (LEDs, switches,
// cycle counter, down-counting timer with sticky expiry). Reads are combinational.
module dm_mmio_responder #(
    parameter int unsigned RAM_WORDS = 1024,
    parameter int unsigned IO_W      = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     addr,
    input  logic [31:0]     writedata,
    input  logic            MemWrite,
    output logic [31:0]     readdata,
    input  logic [IO_W-1:0] sw,
    output logic [IO_W-1:0] led,
    output logic            timer_irq
);

    localparam int unsigned DW = 32;
    localparam int unsigned AW = $clog2(RAM_WORDS);

    localparam logic [5:0] OFF_LED    = 6'h00;
    localparam logic [5:0] OFF_SW     = 6'h01;
    localparam logic [5:0] OFF_CYCLE  = 6'h02;
    localparam logic [5:0] OFF_TLOAD  = 6'h03;
    localparam logic [5:0] OFF_TCTRL  = 6'h04;
    localparam logic [5:0] OFF_TCOUNT = 6'h05;

    logic [DW-1:0]   ram [RAM_WORDS];
    logic [AW-1:0]   ram_idx;
    logic            is_ram;
    logic            is_io;
    logic [5:0]      io_word;
    logic            ram_we;
    logic            io_we;
    logic            wr_led;
    logic            wr_tload;
    logic            wr_tctrl;
    logic            unused_addr_bits;

    logic [IO_W-1:0] sw_meta;
    logic [IO_W-1:0] sw_sync;
    logic [DW-1:0]   cycle;
    logic [DW-1:0]   tload;
    logic [DW-1:0]   tcount;
    logic            tmr_en;
    logic            tmr_auto;
    logic            tmr_exp;

    logic            expire;
    logic [DW-1:0]   tcount_nxt;
    logic            tmr_exp_nxt;

    // Address decode; byte offset bits are ignored, all accesses are whole words.
    assign ram_idx          = addr[AW+1:2];
    assign is_ram           = (addr[DW-1:AW+2] == '0);
    assign is_io            = (addr[31:8] == 24'hFF_FFFF);
    assign io_word          = addr[7:2];
    assign unused_addr_bits = ^addr[1:0];

    assign ram_we   = MemWrite && is_ram && !rst;
    assign io_we    = MemWrite && is_io && !rst;
    assign wr_led   = io_we && (io_word == OFF_LED);
    assign wr_tload = io_we && (io_word == OFF_TLOAD);
    assign wr_tctrl = io_we && (io_word == OFF_TCTRL);

    assign expire    = tmr_en && (tcount == 32'd1);
    assign timer_irq = tmr_exp;

    // Timer next state: a TLOAD write beats the count, an expiry beats an EXP clear.
    always_comb begin
        tcount_nxt  = tcount;
        tmr_exp_nxt = tmr_exp;
        if (tmr_en && (tcount > 32'd1)) begin
            tcount_nxt = tcount - 32'd1;
        end else if (expire) begin
            tcount_nxt = tmr_auto ? tload : '0;
        end
        if (wr_tload) begin
            tcount_nxt = writedata;
        end
        if (wr_tctrl && writedata[2]) begin
            tmr_exp_nxt = 1'b0;
        end
        if (expire) begin
            tmr_exp_nxt = 1'b1;
        end
    end

    // RAM is never reset; writes are suppressed while rst is high.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_idx] <= writedata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led      <= '0;
            sw_meta  <= '0;
            sw_sync  <= '0;
            cycle    <= '0;
            tload    <= '0;
            tcount   <= '0;
            tmr_en   <= 1'b0;
            tmr_auto <= 1'b0;
            tmr_exp  <= 1'b0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
            cycle   <= cycle + 32'd1;
            tcount  <= tcount_nxt;
            tmr_exp <= tmr_exp_nxt;
            if (wr_led) begin
                led <= writedata[IO_W-1:0];
            end
            if (wr_tload) begin
                tload <= writedata;
            end
            if (wr_tctrl) begin
                tmr_en   <= writedata[0];
                tmr_auto <= writedata[1];
            end
        end
    end

    // Load path: pure function of addr and current state, independent of MemWrite.
    always_comb begin
        readdata = '0;
        if (is_ram) begin
            readdata = ram[ram_idx];
        end else if (is_io) begin
            case (io_word)
                OFF_LED:    readdata = DW'(led);
                OFF_SW:     readdata = DW'(sw_sync);
                OFF_CYCLE:  readdata = cycle;
                OFF_TLOAD:  readdata = tload;
                OFF_TCTRL:  readdata = DW'({tmr_exp, tmr_auto, tmr_en});
                OFF_TCOUNT: readdata = tcount;
                default:    readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_mmio_responder.sv
// Directed bench for dm_mmio_responder: vector table for RAM/IO decode plus
// hand-written sequences for synchronizer, cycle counter, timer races and reset.
module tb_dm_mmio_responder;

    localparam logic [31:0] A_LED    = 32'hFFFF_FF00;
    localparam logic [31:0] A_SW     = 32'hFFFF_FF04;
    localparam logic [31:0] A_CYCLE  = 32'hFFFF_FF08;
    localparam logic [31:0] A_TLOAD  = 32'hFFFF_FF0C;
    localparam logic [31:0] A_TCTRL  = 32'hFFFF_FF10;
    localparam logic [31:0] A_TCOUNT = 32'hFFFF_FF14;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic        MemWrite;
    logic [31:0] readdata;
    logic [15:0] sw;
    logic [15:0] led;
    logic        timer_irq;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
        logic        chk;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[20];

    dm_mmio_responder #(
        .RAM_WORDS (1024),
        .IO_W      (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .writedata (writedata),
        .MemWrite  (MemWrite),
        .readdata  (readdata),
        .sw        (sw),
        .led       (led),
        .timer_irq (timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr      = a;
        writedata = d;
        MemWrite  = 1'b1;
        tick();
        MemWrite  = 1'b0;
    endtask

    task automatic chk_rd(input string name, input logic [31:0] a, input logic [31:0] expv);
        addr = a;
        #1;
        chk(name, readdata, expv);
    endtask

    initial begin
        rst       = 1'b1;
        addr      = '0;
        writedata = '0;
        MemWrite  = 1'b0;
        sw        = '0;

        //            we    addr            wdata           chk   expected (pre-edge read)
        vecs[0]  = '{1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0, 32'h0,          "ram_w0"};
        vecs[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,          "ram_w10"};
        vecs[2]  = '{1'b1, 32'h0000_0013, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF,  "ram_same_cycle_old"};
        vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'h1234_5678,  "ram_rd10"};
        vecs[4]  = '{1'b0, 32'h0000_1000, 32'h0,         1'b1, 32'h0,          "ram_oob_rd"};
        vecs[5]  = '{1'b1, 32'h0000_1000, 32'h5555_5555, 1'b1, 32'h0,          "ram_oob_wr"};
        vecs[6]  = '{1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'hA5A5_A5A5,  "ram_no_alias"};
        vecs[7]  = '{1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 1'b0, 32'h0,          "ram_w_last"};
        vecs[8]  = '{1'b0, 32'h0000_0FFC, 32'h0,         1'b1, 32'hCAFE_F00D,  "ram_rd_last"};
        vecs[9]  = '{1'b1, A_LED,         32'hABCD_1234, 1'b1, 32'h0,          "led_wr_old"};
        vecs[10] = '{1'b0, A_LED,         32'h0,         1'b1, 32'h0000_1234,  "led_rd"};
        vecs[11] = '{1'b1, 32'hFFFF_FF18, 32'hFFFF_FFFF, 1'b1, 32'h0,          "io_hole_wr"};
        vecs[12] = '{1'b0, 32'hFFFF_FF03, 32'h0,         1'b1, 32'h0000_1234,  "led_rd_lowbits"};
        vecs[13] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h0,          "unmapped_wr"};
        vecs[14] = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'h1234_5678,  "ram_rd10_again"};
        vecs[15] = '{1'b1, A_SW,          32'h0000_FFFF, 1'b1, 32'h0,          "sw_ro_wr"};
        vecs[16] = '{1'b0, A_SW,          32'h0,         1'b1, 32'h0,          "sw_ro_rd"};
        vecs[17] = '{1'b1, A_TCOUNT,      32'h0000_0007, 1'b1, 32'h0,          "tcount_ro_wr"};
        vecs[18] = '{1'b0, A_TCOUNT,      32'h0,         1'b1, 32'h0,          "tcount_ro_rd"};
        vecs[19] = '{1'b0, 32'hFFFF_FF18, 32'h0,         1'b1, 32'h0,          "io_hole_rd"};

        // Reset state while rst is held
        #2;
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_irq", 32'(timer_irq), 32'h0);
        chk_rd("rst_tcount", A_TCOUNT, 32'h0);
        chk_rd("rst_tctrl", A_TCTRL, 32'h0);

        // Cycle counter from reset release, then wrap
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_rd("cycle_e0", A_CYCLE, 32'd0);
        tick();
        chk_rd("cycle_e1", A_CYCLE, 32'd1);
        repeat (4) tick();
        chk_rd("cycle_e5", A_CYCLE, 32'd5);
        force dut.cycle = 32'hFFFF_FFFF;
        #1;
        release dut.cycle;
        chk_rd("cycle_forced", A_CYCLE, 32'hFFFF_FFFF);
        tick();
        chk_rd("cycle_wrap", A_CYCLE, 32'h0);

        // Table-driven RAM and IO decode
        for (int i = 0; i < 20; i++) begin
            addr      = vecs[i].a;
            writedata = vecs[i].d;
            MemWrite  = vecs[i].we;
            #1;
            if (vecs[i].chk) chk(vecs[i].name, readdata, vecs[i].exp);
            tick();
        end
        MemWrite = 1'b0;
        chk("led_port", 32'(led), 32'h0000_1234);

        // Switch synchronizer: two edges of latency
        sw = 16'h00F0;
        chk_rd("sw_edge0", A_SW, 32'h0);
        tick();
        chk_rd("sw_edge1", A_SW, 32'h0);
        tick();
        chk_rd("sw_edge2", A_SW, 32'h0000_00F0);

        // One-shot timer
        wr(A_TLOAD, 32'd3);
        wr(A_TCTRL, 32'h1);
        chk_rd("os_tc3", A_TCOUNT, 32'd3);
        tick();
        chk_rd("os_tc2", A_TCOUNT, 32'd2);
        tick();
        chk_rd("os_tc1", A_TCOUNT, 32'd1);
        chk("os_irq_pre", 32'(timer_irq), 32'h0);
        tick();
        chk_rd("os_tc0", A_TCOUNT, 32'd0);
        chk("os_irq_set", 32'(timer_irq), 32'h1);
        chk_rd("os_tctrl_exp", A_TCTRL, 32'h5);
        tick();
        chk_rd("os_tc_hold", A_TCOUNT, 32'd0);
        chk("os_irq_sticky", 32'(timer_irq), 32'h1);
        wr(A_TCTRL, 32'h5);
        chk_rd("os_clear_tctrl", A_TCTRL, 32'h1);
        chk("os_irq_clear", 32'(timer_irq), 32'h0);

        // Auto-reload timer and same-cycle races
        wr(A_TCTRL, 32'h4);
        wr(A_TLOAD, 32'd2);
        wr(A_TCTRL, 32'h3);
        chk_rd("ar_tc2a", A_TCOUNT, 32'd2);
        tick();
        chk_rd("ar_tc1a", A_TCOUNT, 32'd1);
        tick();
        chk_rd("ar_reload", A_TCOUNT, 32'd2);
        chk("ar_irq_first", 32'(timer_irq), 32'h1);
        wr(A_TCTRL, 32'h7);
        chk_rd("ar_tc1b", A_TCOUNT, 32'd1);
        chk("ar_irq_cleared", 32'(timer_irq), 32'h0);
        wr(A_TCTRL, 32'h7);
        chk("race_set_wins", 32'(timer_irq), 32'h1);
        chk_rd("race_tctrl", A_TCTRL, 32'h7);
        chk_rd("race_tc_reload", A_TCOUNT, 32'd2);
        tick();
        chk_rd("ar_tc1c", A_TCOUNT, 32'd1);
        wr(A_TLOAD, 32'd9);
        chk_rd("race_load_wins", A_TCOUNT, 32'd9);
        chk_rd("race_tload", A_TLOAD, 32'd9);
        tick();
        chk_rd("ar_tc8", A_TCOUNT, 32'd8);

        // Asynchronous reset mid-count; RAM survives
        wr(32'h0000_0040, 32'h600D_F00D);
        wr(A_LED, 32'h0000_FFFF);
        wr(A_TLOAD, 32'd5);
        chk_rd("pre_rst_tc5", A_TCOUNT, 32'd5);
        chk("pre_rst_led", 32'(led), 32'h0000_FFFF);
        chk("pre_rst_irq", 32'(timer_irq), 32'h1);
        rst = 1'b1;
        #1;
        chk("arst_led", 32'(led), 32'h0);
        chk("arst_irq", 32'(timer_irq), 32'h0);
        chk_rd("arst_tcount", A_TCOUNT, 32'h0);
        chk_rd("arst_tctrl", A_TCTRL, 32'h0);
        chk_rd("arst_tload", A_TLOAD, 32'h0);
        wr(32'h0000_0040, 32'h0000_0BAD);
        wr(A_LED, 32'h0000_FFFF);
        chk("rst_led_wr_ignored", 32'(led), 32'h0);
        rst = 1'b0;
        chk_rd("ram_survives_rst", 32'h0000_0040, 32'h600D_F00D);
        chk_rd("cycle_after_rst", A_CYCLE, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
